exe_stall_ctrl: RTL and testbench
=================================

# exe_stall_ctrl

Stall/flush controller for the ID→EXE→MEM boundary. It sequences the iterative divider for divide instructions sitting in EXE and detects load-use hazards between EXE and ID. From these it drives the hold and bubble controls of the front end, the ID/EXE register and the EXE/MEM register. It sits beside the ID/EXE pipeline register: it reads that register's outputs, and its stall0/clr0 feed the same register's stall/flush inputs.

## Interface
- DIV_MAX_CYCLES, 40, watchdog limit in cycles for a divide; legal range 2..63.
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- irq  in  1  exception/interrupt flush request; overrides every stall
- ext_stall  in  1  downstream (MEM) hold request
- ID_EXE_is_div_data  in  1  EXE instruction is a divide
- ID_EXE_is_sign_div_data  in  1  divide is signed
- ID_EXE_load_type_data  in  4  nonzero means the EXE instruction is a load
- ID_EXE_wreg_data  in  1  EXE instruction writes the register file
- ID_EXE_rt_data  in  5  load destination register
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- div_valid  in  1  divider result ready, one-cycle pulse
- div_start  out  1  one-cycle pulse that launches the divider
- div_sign  out  1  signed-divide select, valid with div_start
- div_abort  out  1  one-cycle pulse that cancels the divider
- div_done  out  1  HI/LO write qualifier for the divide result
- div_err  out  1  sticky flag: watchdog expired
- stall_front  out  1  hold PC and IF/ID
- stall0  out  1  hold ID/EXE
- clr0  out  1  bubble into ID/EXE
- exe_mem_clr  out  1  bubble into EXE/MEM
- stall_cycles  out  32  stall performance counter (see Configuration)

## Operation
- The divide FSM has three states, IDLE, BUSY and DONE, with a 6-bit counter div_cnt.
- IDLE:
  - If ID_EXE_is_div_data=1 and irq=0, pulse div_start, drive div_sign=ID_EXE_is_sign_div_data, clear div_cnt and go to BUSY.
- BUSY:
  - stall_front=stall0=1. exe_mem_clr=~ext_stall.
  - div_cnt increments each cycle.
  - If div_valid=1 and ext_stall=0: drive div_done=1, stall0=0, stall_front=0 and exe_mem_clr=0, then go to IDLE.
  - If div_valid=1 and ext_stall=1: go to DONE.
  - If div_cnt reaches DIV_MAX_CYCLES-1 without div_valid: pulse div_abort, set div_err, go to IDLE. The EXE instruction then completes with div_done=0.
- DONE:
  - stall0=stall_front=1 while ext_stall=1.
  - When ext_stall falls, drive div_done=1 with stalls released, then go to IDLE.
- irq in any state:
  - Go to IDLE. Pulse div_abort if the state was BUSY or DONE.
  - stall_front=stall0=exe_mem_clr=clr0=0.
  - In IDLE, div_start is suppressed.
- Load-use hazard: lu = (ID_EXE_load_type_data≠0) & ID_EXE_wreg_data & (ID_EXE_rt_data≠0) & (ID_EXE_rt_data==id_rs | ID_EXE_rt_data==id_rt).
- In IDLE with lu=1, no irq and no ext_stall: stall_front=1 and clr0=1 for exactly one cycle. The hazard then clears because the load moves on.
- ext_stall=1 in IDLE: stall_front=stall0=1, clr0=0, exe_mem_clr=0.
- A divide in EXE and a load-use hazard cannot coexist, since the EXE instruction is either a divide or a load. The divide path takes priority by construction.

## Timing
- All outputs are combinational from state and inputs. The only registers are state, div_cnt, div_err, a one-cycle "start issued" guard and the optional counter.
- Reset values:
  - state=IDLE, div_cnt=0, div_err=0, stall_cycles=0.
  - All outputs are 0 while rst_n=0.
- Divide latency is the cycle of div_start plus N divider cycles. The instruction leaves EXE at the edge that ends the div_valid cycle.
- Back-to-back divides: the second div_start occurs in the first cycle the new divide is in EXE. There are no idle cycles.
- div_valid arriving while in IDLE is ignored.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately. No div_abort is issued; the divider is reset in parallel.

## Configuration
- STALL_PERF_CNT_EN defined:
  - stall_cycles increments on every clk where stall_front=1. It wraps at 2^32-1 → 0.
  - It is reset to 0 only by rst_n.
- Not defined: stall_cycles is tied to 0 and no counter register is instantiated.

## Structure
- The shared pipeline package holds:
  - the state encoding typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - the LOAD_NONE=4'd0 constant
  - the register-index width constant (5).
- One sub-module, lu_hazard_det, holds the purely combinational load-use compare. The FSM and counters stay in the top module.

## Test plan
- Unsigned divide, div_valid 32 cycles after div_start, ext_stall=0 → div_sign=0; stall0=1 for 32 cycles; div_done=1 in the valid cycle; state returns to IDLE.
- Signed divide with ext_stall=1 during the div_valid cycle and for 3 more cycles → state DONE; stall0 held for 4 cycles; div_done asserted once, in the cycle ext_stall drops.
- Divider never responds, DIV_MAX_CYCLES=40 → div_abort pulses 40 cycles after div_start; div_err=1 and stays 1 until reset.
- irq asserted 10 cycles into BUSY → div_abort pulse that cycle; all stall/clr outputs 0; next-cycle state IDLE.
- Load to rt=5 in EXE with id_rs=5 → stall_front=1 and clr0=1 for one cycle. Repeat with rt=0 → no stall.
- With STALL_PERF_CNT_EN, run the first scenario → stall_cycles=32 afterwards. Without the macro → stall_cycles=0.

Source files
------------

// File: rtl/exe_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// exe_stall_ctrl_pkg
// Shared pipeline definitions used by the EXE stall/flush controller:
//   - div_state_e : divide sequencer state encoding (IDLE/BUSY/DONE)
//   - LOAD_NONE   : load_type value meaning "not a load"
//   - REG_IDX_W   : register-index width
//   - is_load()   : helper that classifies a load_type field
// ----------------------------------------------------------------------------
package exe_stall_ctrl_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int LOAD_TYPE_W = 4;

    localparam logic [LOAD_TYPE_W-1:0] LOAD_NONE = 4'd0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Any nonzero load_type encodes some flavour of load.
    function automatic logic is_load(input logic [LOAD_TYPE_W-1:0] load_type);
        return (load_type != LOAD_NONE);
    endfunction

endpackage

// File: rtl/exe_stall_ctrl_lu_hazard_det.sv
// ----------------------------------------------------------------------------
// lu_hazard_det
// Purely combinational load-use hazard detector. Flags when the instruction
// in EXE is a load writing a nonzero register that the instruction in ID
// reads through rs or rt.
// Ports:
//   exe_load_type  in  4  load type of the EXE instruction (0 = not a load)
//   exe_wreg       in  1  EXE instruction writes the register file
//   exe_rt         in  5  load destination register
//   id_rs, id_rt   in  5  source registers of the ID instruction
//   lu_hazard      out 1  load-use hazard present
// ----------------------------------------------------------------------------
module lu_hazard_det
    import exe_stall_ctrl_pkg::*;
(
    input  logic [LOAD_TYPE_W-1:0] exe_load_type,
    input  logic                   exe_wreg,
    input  logic [REG_IDX_W-1:0]   exe_rt,
    input  logic [REG_IDX_W-1:0]   id_rs,
    input  logic [REG_IDX_W-1:0]   id_rt,
    output logic                   lu_hazard
);

    logic rt_nonzero_s;
    logic rt_match_s;

    // Compare the load destination against both ID sources; r0 never hazards.
    always_comb begin
        rt_nonzero_s = (exe_rt != 5'd0);
        rt_match_s   = (exe_rt == id_rs) || (exe_rt == id_rt);
        lu_hazard    = is_load(exe_load_type) & exe_wreg & rt_nonzero_s & rt_match_s;
    end

endmodule

// File: rtl/exe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// exe_stall_ctrl
// Stall/flush controller for the ID->EXE->MEM boundary. Sequences the
// iterative divider for a divide sitting in EXE (IDLE/BUSY/DONE with a
// watchdog), detects load-use hazards between EXE and ID, and drives the
// hold/bubble controls of the front end, ID/EXE and EXE/MEM registers.
// Outputs are combinational from state and inputs and forced to 0 while
// rst_n is low.
//
// Optional feature: define STALL_PERF_CNT_EN to build a 32-bit counter of
// cycles with stall_front=1 (wraps, cleared only by rst_n). Without it,
// stall_cycles is tied to 0.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   irq                         flush request, overrides every stall
//   ext_stall                   downstream (MEM) hold request
//   ID_EXE_is_div_data          EXE instruction is a divide
//   ID_EXE_is_sign_div_data     divide is signed
//   ID_EXE_load_type_data [3:0] nonzero = EXE instruction is a load
//   ID_EXE_wreg_data            EXE instruction writes the register file
//   ID_EXE_rt_data [4:0]        load destination register
//   id_rs, id_rt [4:0]          ID instruction source registers
//   div_valid                   divider result ready (pulse)
//   div_start / div_sign        divider launch pulse and signed select
//   div_abort                   divider cancel pulse
//   div_done                    HI/LO write qualifier
//   div_err                     sticky watchdog-expired flag
//   stall_front, stall0, clr0   front-end hold, ID/EXE hold, ID/EXE bubble
//   exe_mem_clr                 EXE/MEM bubble
//   stall_cycles [31:0]         stall performance counter
// ----------------------------------------------------------------------------
module exe_stall_ctrl
    import exe_stall_ctrl_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = 40
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   irq,
    input  logic                   ext_stall,
    input  logic                   ID_EXE_is_div_data,
    input  logic                   ID_EXE_is_sign_div_data,
    input  logic [LOAD_TYPE_W-1:0] ID_EXE_load_type_data,
    input  logic                   ID_EXE_wreg_data,
    input  logic [REG_IDX_W-1:0]   ID_EXE_rt_data,
    input  logic [REG_IDX_W-1:0]   id_rs,
    input  logic [REG_IDX_W-1:0]   id_rt,
    input  logic                   div_valid,
    output logic                   div_start,
    output logic                   div_sign,
    output logic                   div_abort,
    output logic                   div_done,
    output logic                   div_err,
    output logic                   stall_front,
    output logic                   stall0,
    output logic                   clr0,
    output logic                   exe_mem_clr,
    output logic [31:0]            stall_cycles
);

    localparam logic [1:0] ST_IDLE = DIV_IDLE;
    localparam logic [1:0] ST_BUSY = DIV_BUSY;
    localparam logic [1:0] ST_DONE = DIV_DONE;

    // Last BUSY count value before the watchdog fires.
    localparam logic [5:0] DIV_CNT_LAST = 6'(DIV_MAX_CYCLES - 1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [5:0] div_cnt_r;
    logic [5:0] div_cnt_nxt_s;
    logic       div_err_r;
    logic       div_err_nxt_s;
    logic       start_guard_r;
    logic       start_guard_nxt_s;

    logic       lu_s;
    logic       div_start_s;
    logic       div_sign_s;
    logic       div_abort_s;
    logic       div_done_s;
    logic       stall_front_s;
    logic       stall0_s;
    logic       clr0_s;
    logic       exe_mem_clr_s;

    lu_hazard_det u_lu_hazard_det (
        .exe_load_type (ID_EXE_load_type_data),
        .exe_wreg      (ID_EXE_wreg_data),
        .exe_rt        (ID_EXE_rt_data),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .lu_hazard     (lu_s)
    );

    // Divide sequencer next-state logic and pipeline hold/bubble decode.
    always_comb begin
        state_nxt_s       = state_r;
        div_cnt_nxt_s     = div_cnt_r;
        div_err_nxt_s     = div_err_r;
        start_guard_nxt_s = 1'b0;
        div_start_s       = 1'b0;
        div_sign_s        = 1'b0;
        div_abort_s       = 1'b0;
        div_done_s        = 1'b0;
        stall_front_s     = 1'b0;
        stall0_s          = 1'b0;
        clr0_s            = 1'b0;
        exe_mem_clr_s     = 1'b0;

        if (irq) begin
            // Flush wins: drop every hold and cancel an in-flight divide.
            state_nxt_s = ST_IDLE;
            div_abort_s = (state_r != ST_IDLE);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ID_EXE_is_div_data && !start_guard_r) begin
                        // Divide just arrived in EXE: launch and hold it there.
                        div_start_s   = 1'b1;
                        div_sign_s    = ID_EXE_is_sign_div_data;
                        div_cnt_nxt_s = 6'd0;
                        state_nxt_s   = ST_BUSY;
                        stall_front_s = 1'b1;
                        stall0_s      = 1'b1;
                        exe_mem_clr_s = ~ext_stall;
                    end else if (ext_stall) begin
                        stall_front_s     = 1'b1;
                        stall0_s          = 1'b1;
                        // An aborted divide still parked in EXE must not relaunch.
                        start_guard_nxt_s = start_guard_r;
                    end else if (lu_s) begin
                        // One bubble: the load advances, so the hazard resolves itself.
                        stall_front_s = 1'b1;
                        clr0_s        = 1'b1;
                    end else begin
                        stall_front_s = 1'b0;
                    end
                end

                ST_BUSY: begin
                    div_cnt_nxt_s = div_cnt_r + 6'd1;
                    if (div_valid) begin
                        if (ext_stall) begin
                            // Result ready but MEM is held: park in DONE.
                            state_nxt_s   = ST_DONE;
                            stall_front_s = 1'b1;
                            stall0_s      = 1'b1;
                        end else begin
                            div_done_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (div_cnt_r == DIV_CNT_LAST) begin
                        // Watchdog: give up, let the instruction retire without a result.
                        div_abort_s       = 1'b1;
                        div_err_nxt_s     = 1'b1;
                        state_nxt_s       = ST_IDLE;
                        stall_front_s     = ext_stall;
                        stall0_s          = ext_stall;
                        start_guard_nxt_s = ext_stall;
                    end else begin
                        stall_front_s = 1'b1;
                        stall0_s      = 1'b1;
                        exe_mem_clr_s = ~ext_stall;
                    end
                end

                ST_DONE: begin
                    if (ext_stall) begin
                        stall_front_s = 1'b1;
                        stall0_s      = 1'b1;
                    end else begin
                        div_done_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end

                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state, watchdog counter, sticky error and relaunch guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            div_cnt_r     <= 6'd0;
            div_err_r     <= 1'b0;
            start_guard_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            div_cnt_r     <= div_cnt_nxt_s;
            div_err_r     <= div_err_nxt_s;
            start_guard_r <= start_guard_nxt_s;
        end
    end

    // Outputs are quiet while reset is held, even though inputs may toggle.
    assign div_start   = rst_n & div_start_s;
    assign div_sign    = rst_n & div_sign_s;
    assign div_abort   = rst_n & div_abort_s;
    assign div_done    = rst_n & div_done_s;
    assign div_err     = rst_n & div_err_r;
    assign stall_front = rst_n & stall_front_s;
    assign stall0      = rst_n & stall0_s;
    assign clr0        = rst_n & clr0_s;
    assign exe_mem_clr = rst_n & exe_mem_clr_s;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_r;

    // Count front-end stall cycles; natural 32-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_front) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_exe_stall_ctrl.sv
module tb_exe_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        irq;
    logic        ext_stall;
    logic        is_div;
    logic        is_sign;
    logic [3:0]  load_type;
    logic        wreg;
    logic [4:0]  exe_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        div_valid;
    logic        div_start;
    logic        div_sign;
    logic        div_abort;
    logic        div_done;
    logic        div_err;
    logic        stall_front;
    logic        stall0;
    logic        clr0;
    logic        exe_mem_clr;
    logic [31:0] stall_cycles;

    int checks;
    int failures;

`ifdef STALL_PERF_CNT_EN
    localparam logic [31:0] EXP_PERF = 32'd32;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    exe_stall_ctrl #(.DIV_MAX_CYCLES(40)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .irq                     (irq),
        .ext_stall               (ext_stall),
        .ID_EXE_is_div_data      (is_div),
        .ID_EXE_is_sign_div_data (is_sign),
        .ID_EXE_load_type_data   (load_type),
        .ID_EXE_wreg_data        (wreg),
        .ID_EXE_rt_data          (exe_rt),
        .id_rs                   (id_rs),
        .id_rt                   (id_rt),
        .div_valid               (div_valid),
        .div_start               (div_start),
        .div_sign                (div_sign),
        .div_abort               (div_abort),
        .div_done                (div_done),
        .div_err                 (div_err),
        .stall_front             (stall_front),
        .stall0                  (stall0),
        .clr0                    (clr0),
        .exe_mem_clr             (exe_mem_clr),
        .stall_cycles            (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lt;
        logic       wr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       es;
        logic       ir;
        logic       dv;
        logic [4:0] exp;   // {stall_front, stall0, clr0, exe_mem_clr, div_start}
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        irq = 1'b0; ext_stall = 1'b0; is_div = 1'b0; is_sign = 1'b0;
        load_type = 4'd0; wreg = 1'b0; exe_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        div_valid = 1'b0;
    endtask

    function automatic logic [4:0] ctl();
        return {stall_front, stall0, clr0, exe_mem_clr, div_start};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int stall_n;
        int done_n;
        int start_n;
        int abort_at;

        checks = 0;
        failures = 0;

        vecs[0]  = '{4'd2,  1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 5'b10100};
        vecs[1]  = '{4'd2,  1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[2]  = '{4'd2,  1'b1, 5'd7,  5'd1,  5'd7, 1'b0, 1'b0, 1'b0, 5'b10100};
        vecs[3]  = '{4'd0,  1'b1, 5'd7,  5'd7,  5'd7, 1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[4]  = '{4'd4,  1'b0, 5'd7,  5'd7,  5'd7, 1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[5]  = '{4'd1,  1'b1, 5'd9,  5'd3,  5'd4, 1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[6]  = '{4'd2,  1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 5'b11000};
        vecs[7]  = '{4'd0,  1'b0, 5'd0,  5'd1,  5'd2, 1'b1, 1'b0, 1'b0, 5'b11000};
        vecs[8]  = '{4'd2,  1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[9]  = '{4'd0,  1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b1, 5'b00000};
        vecs[10] = '{4'd0,  1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 1'b0, 5'b00000};
        vecs[11] = '{4'd15, 1'b1, 5'd31, 5'd31, 5'd8, 1'b0, 1'b0, 1'b0, 5'b10100};

        // Reset with busy-looking inputs: every output must stay low.
        clear_inputs();
        rst_n = 1'b0;
        is_div = 1'b1; ext_stall = 1'b1; load_type = 4'd2; wreg = 1'b1; exe_rt = 5'd5; id_rs = 5'd5;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl", {27'd0, ctl()}, 32'd0);
        check("rst_div", {28'd0, div_sign, div_abort, div_done, div_err}, 32'd0);
        check("rst_perf", stall_cycles, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        // Unsigned divide, div_valid 32 cycles after div_start.
        @(negedge clk);
        is_div = 1'b1; is_sign = 1'b0;
        #1;
        check("s1_start", {30'd0, div_start, div_sign}, 32'd2);
        stall_n = (stall0 === 1'b1) ? 1 : 0;
        done_n = 0;
        start_n = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            div_valid = (k == 32);
            #1;
            if (stall0 === 1'b1) stall_n++;
            if (div_done === 1'b1) done_n++;
            if (div_start === 1'b1) start_n++;
            if (k == 32) begin
                check("s1_valid_ctl", {28'd0, div_done, stall0, stall_front, exe_mem_clr}, 32'h8);
            end
        end
        check("s1_stall0_cycles", stall_n, 32'd32);
        check("s1_done_count", done_n, 32'd1);
        check("s1_no_restart", start_n, 32'd0);

        // Back-to-back divide: start in its first EXE cycle.
        @(negedge clk);
        div_valid = 1'b0;
        #1;
        check("s1_perf", stall_cycles, EXP_PERF);
        check("b2b_start", {31'd0, div_start}, 32'd1);
        @(negedge clk);
        div_valid = 1'b1;
        #1;
        check("b2b_done", {31'd0, div_done}, 32'd1);
        @(negedge clk);
        is_div = 1'b0;
        #1;
        check("idle_valid_ignored", {30'd0, div_done, stall0}, 32'd0);
        @(negedge clk);
        div_valid = 1'b0;

        // Signed divide, ext_stall over the valid cycle plus three more.
        @(negedge clk);
        is_div = 1'b1; is_sign = 1'b1;
        #1;
        check("s2_start", {30'd0, div_start, div_sign}, 32'd3);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        stall_n = 0;
        done_n = 0;
        for (int k = 5; k <= 9; k++) begin
            @(negedge clk);
            div_valid = (k == 5);
            ext_stall = (k <= 8);
            #1;
            if (stall0 === 1'b1) stall_n++;
            if (div_done === 1'b1) done_n++;
            if (k == 5) check("s2_valid_held", {30'd0, stall0, exe_mem_clr}, 32'd2);
            if (k == 9) check("s2_release", {30'd0, div_done, stall0}, 32'd2);
        end
        check("s2_stall0_cycles", stall_n, 32'd4);
        check("s2_done_count", done_n, 32'd1);
        @(negedge clk);
        is_div = 1'b0; is_sign = 1'b0; div_valid = 1'b0;
        #1;
        check("s2_idle", {27'd0, ctl()}, 32'd0);

        // Watchdog: divider never answers.
        @(negedge clk);
        is_div = 1'b1;
        #1;
        check("s3_start", {31'd0, div_start}, 32'd1);
        abort_at = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #1;
            if (div_abort === 1'b1) begin
                abort_at = k;
                break;
            end
        end
        check("s3_abort_cycle", abort_at, 32'd40);
        @(negedge clk);
        is_div = 1'b0;
        #1;
        check("s3_err_set", {31'd0, div_err}, 32'd1);

        // irq ten cycles into BUSY.
        @(negedge clk);
        is_div = 1'b1;
        #1;
        check("s4_start", {31'd0, div_start}, 32'd1);
        for (int k = 1; k <= 9; k++) @(negedge clk);
        @(negedge clk);
        irq = 1'b1;
        #1;
        check("s4_abort", {31'd0, div_abort}, 32'd1);
        check("s4_ctl", {27'd0, ctl()}, 32'd0);
        @(negedge clk);
        irq = 1'b0; is_div = 1'b0; div_valid = 1'b1;
        #1;
        check("s4_idle_after", {29'd0, div_abort, div_done, stall0}, 32'd0);
        @(negedge clk);
        div_valid = 1'b0;

        // Load-use: one bubble, then the load moves on.
        @(negedge clk);
        load_type = 4'd2; wreg = 1'b1; exe_rt = 5'd5; id_rs = 5'd5;
        #1;
        check("s5_lu", {27'd0, ctl()}, 32'b10100);
        @(negedge clk);
        load_type = 4'd0; wreg = 1'b0; exe_rt = 5'd0;
        #1;
        check("s5_lu_clear", {27'd0, ctl()}, 32'd0);

        // Table of IDLE-state decode vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load_type = vecs[i].lt; wreg = vecs[i].wr; exe_rt = vecs[i].ert;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ext_stall = vecs[i].es;
            irq = vecs[i].ir; is_div = vecs[i].dv;
            #1;
            check($sformatf("vec%0d", i), {27'd0, ctl()}, {27'd0, vecs[i].exp});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        check("err_sticky", {31'd0, div_err}, 32'd1);

        // Reset asserted mid-BUSY.
        @(negedge clk);
        is_div = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("s6_rst_ctl", {27'd0, ctl()}, 32'd0);
        check("s6_rst_abort_err", {30'd0, div_abort, div_err}, 32'd0);
        check("s6_rst_perf", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        is_div = 1'b0;
        @(negedge clk);
        #1;
        check("s6_idle", {30'd0, stall0, div_done}, 32'd0);
        @(negedge clk);
        is_div = 1'b1;
        #1;
        check("s6_restart", {31'd0, div_start}, 32'd1);
        @(negedge clk);
        div_valid = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
